// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default feedback taps, checker state encoding and the
// single recurrence used by both the generator and the checker.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } lfsr_state_e;

  // Callers zero-extend to LFSR_MAX_W and truncate the result back to their WIDTH,
  // which yields {x[WIDTH-2:0], ^(x & taps)} for any WIDTH up to LFSR_MAX_W.
  function automatic logic [LFSR_MAX_W-1:0] nxt(input logic [LFSR_MAX_W-1:0] x,
                                               input logic [LFSR_MAX_W-1:0] taps);
    return {x[LFSR_MAX_W-2:0], ^(x & taps)};
  endfunction

endpackage

// File: rtl/lfsr_popcount.sv
// Combinational population count, used to weight errors by flipped bits.
module lfsr_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data,
  output logic [$clog2(WIDTH):0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + {{$clog2(WIDTH){1'b0}}, data[i]};
    end
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Locks onto an LFSR word stream and counts mispredicted words once locked.
// Optional LFSRCHK_BITERR_EN: each counted error adds the number of wrong bits.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(LFSR_TAPS),
  parameter int               LOCK_N = 4,
  parameter int               MISS_N = 3,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int MW    = $clog2(LOCK_N) + 1;
  localparam int XW    = $clog2(MISS_N) + 1;
  localparam int PC_W  = $clog2(WIDTH) + 1;
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_N);
  localparam logic [XW-1:0] MISS_TGT = XW'(MISS_N);

  lfsr_state_e      state;
  logic [WIDTH-1:0] pred;
  logic [MW-1:0]    match_cnt;
  logic [XW-1:0]    miss_cnt;

  logic [WIDTH-1:0] nxt_in;
  logic [WIDTH-1:0] nxt_pred;
  logic             mismatch;
  logic [PC_W-1:0]  err_inc;
  logic [CNT_W-1:0] err_base;
  logic [SUM_W-1:0] err_sum;
  logic [CNT_W-1:0] err_sat;

  assign nxt_in   = WIDTH'(nxt(LFSR_MAX_W'(in_data), LFSR_MAX_W'(TAPS)));
  assign nxt_pred = WIDTH'(nxt(LFSR_MAX_W'(pred), LFSR_MAX_W'(TAPS)));
  assign mismatch = (in_data != pred);

`ifdef LFSRCHK_BITERR_EN
  lfsr_popcount #(.WIDTH(WIDTH)) u_popcount (
    .data  (in_data ^ pred),
    .count (err_inc)
  );
`else
  assign err_inc = PC_W'(1);
`endif

  // A clear in the same cycle as a counted error restarts the count from zero.
  always_comb begin
    err_base = err_clr ? '0 : err_cnt;
    err_sum  = SUM_W'(err_base) + SUM_W'(err_inc);
    err_sat  = (err_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (err_clr) err_cnt <= '0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            if (in_data != '0) begin
              pred      <= nxt_in;
              match_cnt <= '0;
              state     <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (!mismatch) begin
              match_cnt <= match_cnt + 1'b1;
              pred      <= nxt_in;
              if (match_cnt + 1'b1 == LOCK_TGT) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (in_data == '0) begin
              match_cnt <= '0;
              state     <= SEARCH;
            end else begin
              pred      <= nxt_in;
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-run from the prediction so a corrupted word cannot derail it.
            pred <= nxt_pred;
            if (mismatch) begin
              err_pulse <= 1'b1;
              err_cnt   <= err_sat;
              if (miss_cnt + 1'b1 == MISS_TGT) begin
                miss_cnt <= '0;
                locked   <= 1'b0;
                state    <= SEARCH;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
